// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Constants and helpers shared by the fetch, decode and hazard logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int          c_WORD_W       = 32;
    localparam logic [31:0] c_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] c_NOP_INSTR    = 32'hE1A0_0000;  // MOV r0,r0
    localparam logic [31:0] c_PC_INC       = 32'd4;
    localparam logic [31:0] c_CNT_MAX      = 32'hFFFF_FFFF;

    // The F/D register contents as one bundle.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcPlus8;
        logic        valid;
    } fdReg_t;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (value == c_CNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_flopenrc.sv
// ============================================================================
// Module : flopenrc
// Brief  : Width-parameterised register with enable and synchronous clear;
//          clear has priority over enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flopenrc #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic             clk,
    input  logic             En,
    input  logic             Clr,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge clk) begin
        if (Clr) begin
            Q <= CLR_VALUE;
        end else if (En) begin
            Q <= D;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module : fetch_stage
// Brief  : Fetch stage (PCF, next-PC select) plus the F/D pipeline register.
//          Optional performance counters enabled by FETCH_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = c_RESET_VECTOR,
    parameter logic [31:0] NOP_INSTR    = c_NOP_INSTR
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD,
    output logic [31:0] StallCntF,
    output logic [31:0] FlushCntD,
    output logic [31:0] RedirectCnt
);

    logic        w_redirect;
    logic [31:0] w_pcPlus4F;
    logic [31:0] w_pcNext;
    logic        w_pcEn;
    logic        w_fdEn;
    logic        w_fdClr;
    fdReg_t      w_fdNext;

    assign w_redirect = BranchTakenE | PCSrcW;
    assign w_pcPlus4F = PCF + c_PC_INC;

    // A redirect must land even while StallF is held, so it forces the enable.
    assign w_pcEn = ~StallF | w_redirect;

    always_comb begin
        w_pcNext = w_pcPlus4F;
        if (BranchTakenE) begin
            w_pcNext = ALUResultE;
        end else if (PCSrcW) begin
            w_pcNext = ResultW;
        end
    end

    flopenrc #(
        .WIDTH     (32),
        .CLR_VALUE (RESET_VECTOR)
    ) u_pcReg (
        .clk (clk),
        .En  (w_pcEn),
        .Clr (Reset),
        .D   (w_pcNext),
        .Q   (PCF)
    );

    // A held D instruction is never flushed; the flush lands once StallD drops.
    assign w_fdEn  = ~StallD;
    assign w_fdClr = Reset | (FlushD & ~StallD);

    always_comb begin
        w_fdNext.instr   = InstrF;
        w_fdNext.pcPlus8 = w_pcPlus4F;
        w_fdNext.valid   = 1'b1;
    end

    flopenrc #(
        .WIDTH     (32),
        .CLR_VALUE (NOP_INSTR)
    ) u_instrDReg (
        .clk (clk),
        .En  (w_fdEn),
        .Clr (w_fdClr),
        .D   (w_fdNext.instr),
        .Q   (InstrD)
    );

    flopenrc #(
        .WIDTH     (32),
        .CLR_VALUE (32'd0)
    ) u_pcPlus8DReg (
        .clk (clk),
        .En  (w_fdEn),
        .Clr (w_fdClr),
        .D   (w_fdNext.pcPlus8),
        .Q   (PCPlus8D)
    );

    flopenrc #(
        .WIDTH     (1),
        .CLR_VALUE (1'b0)
    ) u_validDReg (
        .clk (clk),
        .En  (w_fdEn),
        .Clr (w_fdClr),
        .D   (w_fdNext.valid),
        .Q   (ValidD)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stallCntF;
    logic [31:0] r_flushCntD;
    logic [31:0] r_redirectCnt;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_stallCntF   <= 32'd0;
            r_flushCntD   <= 32'd0;
            r_redirectCnt <= 32'd0;
        end else begin
            // A stall overridden by a redirect is not a lost fetch cycle.
            if (StallF && !w_redirect) begin
                r_stallCntF <= satInc(r_stallCntF);
            end
            if (FlushD && !StallD) begin
                r_flushCntD <= satInc(r_flushCntD);
            end
            if (w_redirect) begin
                r_redirectCnt <= satInc(r_redirectCnt);
            end
        end
    end

    assign StallCntF   = r_stallCntF;
    assign FlushCntD   = r_flushCntD;
    assign RedirectCnt = r_redirectCnt;
`else
    assign StallCntF   = 32'd0;
    assign FlushCntD   = 32'd0;
    assign RedirectCnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module : tb_fetch_stage
// Brief  : Directed self-checking bench for fetch_stage with a queued model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif
    localparam logic [31:0] c_NOP   = 32'hE1A0_0000;
    localparam logic [31:0] c_CONST = 32'hE3A0_1005;

    logic        clk = 1'b0;
    logic        Reset, StallF, StallD, FlushD, BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW, InstrF;
    logic [31:0] PCF, InstrD, PCPlus8D, StallCntF, FlushCntD, RedirectCnt;
    logic        ValidD;
    logic        useConst;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instrD;
        logic [31:0] pc8D;
        logic        validD;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [31:0] rc;
    } exp_t;

    exp_t sbq[$];
    exp_t m;

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb InstrF = useConst ? c_CONST : memWord(PCF);

    fetch_stage u_dut (
        .clk          (clk),
        .Reset        (Reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .BranchTakenE (BranchTakenE),
        .ALUResultE   (ALUResultE),
        .PCSrcW       (PCSrcW),
        .ResultW      (ResultW),
        .InstrF       (InstrF),
        .PCF          (PCF),
        .InstrD       (InstrD),
        .PCPlus8D     (PCPlus8D),
        .ValidD       (ValidD),
        .StallCntF    (StallCntF),
        .FlushCntD    (FlushCntD),
        .RedirectCnt  (RedirectCnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare after the edge.
    task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                        input logic bt, input logic [31:0] alu,
                        input logic ps, input logic [31:0] res);
        exp_t        e;
        exp_t        got;
        logic [31:0] instrF;
        logic [31:0] pc4;
        Reset = rst; StallF = sf; StallD = sd; FlushD = fd;
        BranchTakenE = bt; ALUResultE = alu; PCSrcW = ps; ResultW = res;
        instrF = useConst ? c_CONST : memWord(m.pc);
        pc4    = m.pc + 32'd4;
        e      = m;
        if (rst) begin
            e.pc = 32'h0; e.instrD = c_NOP; e.pc8D = 32'h0; e.validD = 1'b0;
            e.sc = 32'h0; e.fc = 32'h0; e.rc = 32'h0;
        end else begin
            if (bt)       e.pc = alu;
            else if (ps)  e.pc = res;
            else if (!sf) e.pc = pc4;
            if (!sd) begin
                if (fd) begin
                    e.instrD = c_NOP; e.pc8D = 32'h0; e.validD = 1'b0;
                end else begin
                    e.instrD = instrF; e.pc8D = pc4; e.validD = 1'b1;
                end
            end
            if (c_PERF) begin
                if (sf && !(bt || ps)) e.sc = sat(e.sc);
                if (fd && !sd)         e.fc = sat(e.fc);
                if (bt || ps)          e.rc = sat(e.rc);
            end
        end
        sbq.push_back(e);
        m = e;
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        check("PCF",         PCF,                  got.pc);
        check("InstrD",      InstrD,               got.instrD);
        check("PCPlus8D",    PCPlus8D,             got.pc8D);
        check("ValidD",      {31'd0, ValidD},      {31'd0, got.validD});
        check("StallCntF",   StallCntF,            got.sc);
        check("FlushCntD",   FlushCntD,            got.fc);
        check("RedirectCnt", RedirectCnt,          got.rc);
    endtask

    initial begin
        m        = '{32'h0, c_NOP, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        useConst = 1'b1;
        Reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        BranchTakenE = 1'b0; ALUResultE = 32'h0; PCSrcW = 1'b0; ResultW = 32'h0;

        // Reset for two cycles, then sequential fetch of a constant word.
        step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        check("rst_PCF",    PCF,              32'h0);
        check("rst_InstrD", InstrD,           c_NOP);
        check("rst_ValidD", {31'd0, ValidD},  32'd0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        check("t1_PCF",      PCF,             32'h4);
        check("t1_InstrD",   InstrD,          c_CONST);
        check("t1_PCPlus8D", PCPlus8D,        32'h4);
        check("t1_ValidD",   {31'd0, ValidD}, 32'd1);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        check("t1_PCF_10", PCF, 32'h10);

        // Branch overrides StallF while FlushD bubbles D.
        useConst = 1'b0;
        step(0, 1, 0, 1, 1, 32'h40, 0, 32'h0);
        check("t2_PCF",    PCF,             32'h40);
        check("t2_ValidD", {31'd0, ValidD}, 32'd0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        check("t2_InstrD",   InstrD,   memWord(32'h40));
        check("t2_PCPlus8D", PCPlus8D, 32'h44);

        // Execute branch beats Writeback PC write.
        step(0, 0, 0, 0, 1, 32'h80, 1, 32'h200);
        check("t3_PCF", PCF, 32'h80);
        step(0, 0, 0, 0, 0, 32'h0, 1, 32'h200);
        check("t3_PCF_W", PCF, 32'h200);

        // Full stall for three cycles at PCF=0x20.
        step(0, 0, 0, 0, 1, 32'h20, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h20, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        check("t4_PCF",       PCF,       32'h20);
        check("t4_InstrD",    InstrD,    memWord(32'h24));
        check("t4_StallCntF", StallCntF, c_PERF ? 32'd3 : 32'd0);

        // StallD holds D against FlushD, then the flush takes effect.
        step(0, 1, 1, 1, 0, 32'h0, 0, 32'h0);
        check("t5_held", InstrD, memWord(32'h24));
        step(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        check("t5_InstrD",    InstrD,          c_NOP);
        check("t5_ValidD",    {31'd0, ValidD}, 32'd0);
        check("t5_FlushCntD", FlushCntD,       c_PERF ? 32'd2 : 32'd0);

        // PC wrap, then Reset wins over a stall and a branch.
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        check("t6_wrap",     PCF,      32'h0);
        check("t6_wrap_p8D", PCPlus8D, 32'h0);
        step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        step(1, 1, 1, 1, 1, 32'h1234, 1, 32'h5678);
        check("t6_rst_PCF", PCF,         32'h0);
        check("t6_rst_cnt", RedirectCnt, 32'd0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
